// File: rtl/conv_pkg.sv
// Shared types and defaults for the 3x3 convolution window scheduler.
package conv_pkg;

    localparam int unsigned SIZE_DEF      = 3;
    localparam int unsigned WIDTH_BIT_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef logic [WIDTH_BIT_DEF-1:0] pix_t;

    // Row-major window, [0][0] is the top-left pixel.
    typedef pix_t [SIZE_DEF-1:0][SIZE_DEF-1:0] window_t;

endpackage

// File: rtl/conv_line_buffer.sv
// One image line of pixel storage; the read at addr returns the old contents
// in the same cycle the new pixel is written there.
module conv_line_buffer #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned WIDTH_BIT = 8
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH_BIT-1:0]     wdata,
    output logic [WIDTH_BIT-1:0]     rdata
);

    logic [WIDTH_BIT-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/conv_window_sched.sv
// Raster-scan window scheduler: builds SIZExSIZE windows from a pixel stream,
// hands each one to the external conv unit and streams out tagged results.
module conv_window_sched
    import conv_pkg::*;
#(
    parameter int unsigned SIZE      = SIZE_DEF,
    parameter int unsigned WIDTH_BIT = WIDTH_BIT_DEF,
    parameter int unsigned IMG_W     = 8,
    parameter int unsigned IMG_H     = 8
) (
    input  logic                                     clock,
    input  logic                                     nreset,
    input  logic                                     start_i,
    input  logic [WIDTH_BIT-1:0]                     pix_i,
    input  logic                                     pix_valid_i,
    output logic                                     pix_ready_o,
    output logic [SIZE-1:0][SIZE-1:0][WIDTH_BIT-1:0] win_o,
    input  logic [WIDTH_BIT-1:0]                     conv_i,
    output logic [WIDTH_BIT-1:0]                     res_o,
    output logic [$clog2(IMG_H)-1:0]                 res_row_o,
    output logic [$clog2(IMG_W)-1:0]                 res_col_o,
    output logic                                     res_valid_o,
    input  logic                                     res_ready_i,
    output logic                                     busy_o,
    output logic                                     done_o
);

    localparam int unsigned RW = $clog2(IMG_H);
    localparam int unsigned CW = $clog2(IMG_W);

    state_t               state, state_n;
    logic [RW-1:0]        row, row_l;
    logic [CW-1:0]        col, col_l;
    logic                 win_vld, win_vld_n, res_valid_n, done_n;
    logic                 acc, slot_free, flag, last_pix;
    logic [WIDTH_BIT-1:0] lb_rd  [SIZE-1];
    logic [WIDTH_BIT-1:0] newcol [SIZE];

    // Hold off new pixels while a flagged window is waiting on a blocked output.
    assign pix_ready_o = (state == LOAD) && !(win_vld && res_valid_o && !res_ready_i);
    assign acc         = pix_valid_i && pix_ready_o;
    assign slot_free   = !res_valid_o || res_ready_i;
    assign flag        = acc && (row >= RW'(SIZE-1)) && (col >= CW'(SIZE-1));
    assign last_pix    = acc && (row == RW'(IMG_H-1)) && (col == CW'(IMG_W-1));

    // Incoming column, top (oldest line) to bottom (current pixel).
    always_comb begin
        for (int i = 0; i < SIZE-1; i++) begin
            newcol[i] = lb_rd[i];
        end
        newcol[SIZE-1] = pix_i;
    end

    for (genvar i = 0; i < SIZE-1; i++) begin : g_lb
        conv_line_buffer #(
            .DEPTH    (IMG_W),
            .WIDTH_BIT(WIDTH_BIT)
        ) u_lb (
            .clock(clock),
            .we   (acc),
            .addr (col),
            .wdata(newcol[i+1]),
            .rdata(lb_rd[i])
        );
    end

    // Next-state and next-flag logic.
    always_comb begin
        state_n     = state;
        win_vld_n   = win_vld;
        res_valid_n = res_valid_o;

        if (flag) begin
            win_vld_n = 1'b1;
        end else if (slot_free) begin
            win_vld_n = 1'b0;
        end

        if (win_vld && slot_free) begin
            res_valid_n = 1'b1;
        end else if (res_ready_i) begin
            res_valid_n = 1'b0;
        end

        case (state)
            IDLE:    if (start_i) state_n = LOAD;
            LOAD:    if (last_pix) state_n = DRAIN;
            DRAIN:   if (!win_vld && !res_valid_o) state_n = IDLE;
            default: state_n = IDLE;
        endcase

        // High during the final DRAIN cycle, i.e. the one that returns to IDLE.
        done_n = (state_n == DRAIN) && !win_vld_n && !res_valid_n;
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state       <= IDLE;
            row         <= '0;
            col         <= '0;
            row_l       <= '0;
            col_l       <= '0;
            win_vld     <= 1'b0;
            win_o       <= '0;
            res_o       <= '0;
            res_row_o   <= '0;
            res_col_o   <= '0;
            res_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            state       <= state_n;
            win_vld     <= win_vld_n;
            res_valid_o <= res_valid_n;
            busy_o      <= (state_n != IDLE);
            done_o      <= done_n;

            if ((state == IDLE) && start_i) begin
                row <= '0;
                col <= '0;
            end else if (acc) begin
                if (col == CW'(IMG_W-1)) begin
                    col <= '0;
                    row <= (row == RW'(IMG_H-1)) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end

            if (acc) begin
                for (int r = 0; r < SIZE; r++) begin
                    for (int c = 0; c < SIZE-1; c++) begin
                        win_o[r][c] <= win_o[r][c+1];
                    end
                    win_o[r][SIZE-1] <= newcol[r];
                end
            end

            if (flag) begin
                row_l <= row;
                col_l <= col;
            end

            // Latched position is the bottom-right pixel; report the top-left.
            if (win_vld && slot_free) begin
                res_o     <= conv_i;
                res_row_o <= row_l - RW'(SIZE-1);
                res_col_o <= col_l - CW'(SIZE-1);
            end
        end
    end

endmodule

// File: tb/tb_conv_window_sched.sv
// Directed bench for conv_window_sched on an 8x8 ramp image with a centre-tap kernel.
module tb_conv_window_sched;

    logic             clock       = 1'b0;
    logic             nreset      = 1'b1;
    logic             start_i     = 1'b0;
    logic [7:0]       pix_i       = '0;
    logic             pix_valid_i = 1'b0;
    logic             pix_ready_o;
    conv_pkg::window_t win_o;
    logic [7:0]       conv_i;
    logic [7:0]       res_o;
    logic [2:0]       res_row_o, res_col_o;
    logic             res_valid_o;
    logic             res_ready_i = 1'b1;
    logic             busy_o, done_o;

    int total = 0, bad = 0;
    int rdy_mode = 0, stall_cnt = 0, cyc = 0, acc_cnt = 0;
    int done_cnt = 0, done_cyc = -1, last_res_cyc = -1;
    logic [13:0] got [$];
    logic [7:0]  stall_val [$];
    logic        stall_prdy [$];
    int          stall_acc [$];

    always #5 clock = ~clock;

    // Centre-only kernel stands in for the external conv unit.
    assign conv_i = win_o[1][1];

    conv_window_sched #(.SIZE(3), .WIDTH_BIT(8), .IMG_W(8), .IMG_H(8)) dut (
        .clock      (clock),
        .nreset     (nreset),
        .start_i    (start_i),
        .pix_i      (pix_i),
        .pix_valid_i(pix_valid_i),
        .pix_ready_o(pix_ready_o),
        .win_o      (win_o),
        .conv_i     (conv_i),
        .res_o      (res_o),
        .res_row_o  (res_row_o),
        .res_col_o  (res_col_o),
        .res_valid_o(res_valid_o),
        .res_ready_i(res_ready_i),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    always @(posedge clock) cyc++;

    // Consumer: 0 always ready, 1 random, 2 stall 10 cycles on the first result.
    always @(posedge clock) begin
        #1;
        case (rdy_mode)
            0: res_ready_i = 1'b1;
            1: res_ready_i = 1'($urandom_range(0, 1));
            default: begin
                if (res_valid_o && stall_cnt < 10) begin
                    res_ready_i = 1'b0;
                    stall_cnt++;
                end else begin
                    res_ready_i = 1'b1;
                end
            end
        endcase
    end

    // Record handshakes and pulses; all checking happens in the test tasks.
    always @(negedge clock) begin
        if (nreset) begin
            if (res_valid_o && !res_ready_i) begin
                stall_val.push_back(res_o);
                stall_prdy.push_back(pix_ready_o);
                stall_acc.push_back(acc_cnt);
            end
            if (pix_valid_i && pix_ready_o) acc_cnt++;
            if (res_valid_o && res_ready_i) begin
                got.push_back({res_o, res_row_o, res_col_o});
                last_res_cyc = cyc;
            end
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // Expected i-th result: centre pixel (r+1,c+1) of the ramp, tagged (r,c).
    function automatic logic [13:0] exp_res(input int i);
        int r, c;
        r = i / 6;
        c = i % 6;
        return {8'((r + 1) * 8 + c + 1), 3'(r), 3'(c)};
    endfunction

    task automatic clear_log();
        got.delete();
        stall_val.delete();
        stall_prdy.delete();
        stall_acc.delete();
        acc_cnt      = 0;
        done_cnt     = 0;
        done_cyc     = -1;
        last_res_cyc = -1;
        stall_cnt    = 0;
    endtask

    task automatic do_start();
        @(posedge clock); #1 start_i = 1'b1;
        @(posedge clock); #1 start_i = 1'b0;
    endtask

    // Offer ramp pixels until n are accepted; optionally pulse start_i at pixel start_at.
    task automatic feed(input int n, input bit gaps, input int start_at, output int fed);
        int k = 0;
        int guard = 0;
        while (k < n && guard < 3000) begin
            @(posedge clock); #1;
            pix_valid_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            pix_i       = 8'(k);
            start_i     = (k == start_at);
            @(negedge clock);
            if (pix_valid_i && pix_ready_o) k++;
            guard++;
        end
        @(posedge clock); #1;
        pix_valid_i = 1'b0;
        start_i     = 1'b0;
        fed = k;
    endtask

    task automatic wait_done(output bit ok);
        int g = 0;
        while (done_cnt == 0 && g < 300) begin
            @(negedge clock); #1;
            g++;
        end
        ok = (done_cnt > 0);
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #1 nreset = 1'b0;
        #1;
        total++;
        if ({pix_ready_o, res_valid_o, busy_o, done_o} !== 4'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=0000", {pix_ready_o, res_valid_o, busy_o, done_o});
        end
        total++;
        if ({res_o, res_row_o, res_col_o} !== 14'h0) begin
            bad++;
            $display("FAIL reset_res got=%h exp=0", {res_o, res_row_o, res_col_o});
        end
        total++;
        if (win_o !== '0) begin
            bad++;
            $display("FAIL reset_win got=%h exp=0", win_o);
        end
        @(posedge clock); #1 nreset = 1'b1;
        repeat (3) begin
            @(posedge clock); #1;
            total++;
            if (pix_ready_o !== 1'b0 || busy_o !== 1'b0) begin
                bad++;
                $display("FAIL idle_ready got=%b%b exp=00", pix_ready_o, busy_o);
            end
        end
        do_start();
        total++;
        if (pix_ready_o !== 1'b1 || busy_o !== 1'b1) begin
            bad++;
            $display("FAIL start_ready got=%b%b exp=11", pix_ready_o, busy_o);
        end
        nreset = 1'b0;
        #1;
        total++;
        if (pix_ready_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_load got=%b%b exp=00", pix_ready_o, busy_o);
        end
        @(posedge clock); #1 nreset = 1'b1;
    endtask

    task automatic test_ramp();
        int fed;
        bit ok;
        rdy_mode = 0;
        clear_log();
        do_start();
        feed(64, 1'b0, -1, fed);
        wait_done(ok);
        total++;
        if (fed !== 64 || !ok) begin
            bad++;
            $display("FAIL ramp_timeout fed=%0d done=%0b exp 64/1", fed, ok);
        end
        total++;
        if (got.size() !== 36) begin
            bad++;
            $display("FAIL ramp_count got=%0d exp=36", got.size());
        end
        for (int i = 0; i < got.size() && i < 36; i++) begin
            total++;
            if (got[i] !== exp_res(i)) begin
                bad++;
                $display("FAIL ramp_res[%0d] got=%h exp=%h", i, got[i], exp_res(i));
            end
        end
        total++;
        if (done_cnt !== 1 || done_cyc !== last_res_cyc + 1 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL ramp_done cnt=%0d cyc=%0d last=%0d busy=%b exp 1/last+1/0",
                     done_cnt, done_cyc, last_res_cyc, busy_o);
        end
    endtask

    task automatic test_backpressure();
        int fed;
        bit ok;
        rdy_mode = 2;
        clear_log();
        do_start();
        feed(64, 1'b0, -1, fed);
        wait_done(ok);
        rdy_mode = 0;
        total++;
        if (fed !== 64 || !ok) begin
            bad++;
            $display("FAIL bp_timeout fed=%0d done=%0b exp 64/1", fed, ok);
        end
        total++;
        if (stall_val.size() !== 10) begin
            bad++;
            $display("FAIL bp_stall_len got=%0d exp=10", stall_val.size());
        end
        // Held result is 9; pixel 19 got in before the stall and nothing after.
        for (int i = 0; i < stall_val.size(); i++) begin
            total++;
            if (stall_val[i] !== 8'd9 || stall_prdy[i] !== 1'b0 || stall_acc[i] !== 20) begin
                bad++;
                $display("FAIL bp_hold[%0d] res=%0d rdy=%b acc=%0d exp 9/0/20",
                         i, stall_val[i], stall_prdy[i], stall_acc[i]);
            end
        end
        total++;
        if (got.size() !== 36) begin
            bad++;
            $display("FAIL bp_count got=%0d exp=36", got.size());
        end
        for (int i = 0; i < got.size() && i < 36; i++) begin
            total++;
            if (got[i] !== exp_res(i)) begin
                bad++;
                $display("FAIL bp_res[%0d] got=%h exp=%h", i, got[i], exp_res(i));
            end
        end
    endtask

    task automatic test_random();
        int fed;
        bit ok;
        rdy_mode = 1;
        clear_log();
        do_start();
        feed(64, 1'b1, -1, fed);
        wait_done(ok);
        rdy_mode = 0;
        total++;
        if (fed !== 64 || !ok) begin
            bad++;
            $display("FAIL rnd_timeout fed=%0d done=%0b exp 64/1", fed, ok);
        end
        total++;
        if (got.size() !== 36) begin
            bad++;
            $display("FAIL rnd_count got=%0d exp=36", got.size());
        end
        for (int i = 0; i < got.size() && i < 36; i++) begin
            total++;
            if (got[i] !== exp_res(i)) begin
                bad++;
                $display("FAIL rnd_res[%0d] got=%h exp=%h", i, got[i], exp_res(i));
            end
        end
        total++;
        if (done_cnt !== 1 || done_cyc !== last_res_cyc + 1) begin
            bad++;
            $display("FAIL rnd_done cnt=%0d cyc=%0d last=%0d exp 1/last+1", done_cnt, done_cyc, last_res_cyc);
        end
    endtask

    task automatic test_midreset();
        int fed;
        bit ok;
        rdy_mode = 0;
        clear_log();
        do_start();
        feed(20, 1'b0, -1, fed);
        nreset = 1'b0;
        #1;
        total++;
        if ({pix_ready_o, res_valid_o, busy_o, done_o} !== 4'b0 || {res_o, res_row_o, res_col_o} !== 14'h0) begin
            bad++;
            $display("FAIL midrst_out got=%b/%h exp 0000/0", {pix_ready_o, res_valid_o, busy_o, done_o},
                     {res_o, res_row_o, res_col_o});
        end
        total++;
        if (win_o !== '0) begin
            bad++;
            $display("FAIL midrst_win got=%h exp=0", win_o);
        end
        clear_log();
        @(posedge clock); #1 nreset = 1'b1;
        repeat (3) @(posedge clock);
        do_start();
        feed(64, 1'b0, -1, fed);
        wait_done(ok);
        total++;
        if (fed !== 64 || !ok) begin
            bad++;
            $display("FAIL midrst_timeout fed=%0d done=%0b exp 64/1", fed, ok);
        end
        total++;
        if (got.size() !== 36) begin
            bad++;
            $display("FAIL midrst_count got=%0d exp=36", got.size());
        end
        for (int i = 0; i < got.size() && i < 36; i++) begin
            total++;
            if (got[i] !== exp_res(i)) begin
                bad++;
                $display("FAIL midrst_res[%0d] got=%h exp=%h", i, got[i], exp_res(i));
            end
        end
    endtask

    task automatic test_restart();
        int fed;
        int g = 0;
        bit ok;
        rdy_mode = 0;
        clear_log();
        do_start();
        feed(64, 1'b0, 30, fed);
        do begin
            @(negedge clock);
            g++;
        end while (done_o !== 1'b1 && g < 300);
        total++;
        if (fed !== 64 || done_o !== 1'b1) begin
            bad++;
            $display("FAIL rst_f1_timeout fed=%0d done=%b exp 64/1", fed, done_o);
        end
        start_i = 1'b1;
        @(posedge clock); #1 start_i = 1'b0;
        total++;
        if (busy_o !== 1'b0 || pix_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL done_cycle_start busy=%b rdy=%b exp 0/0", busy_o, pix_ready_o);
        end
        total++;
        if (got.size() !== 36 || done_cnt !== 1) begin
            bad++;
            $display("FAIL rst_f1_count got=%0d done=%0d exp 36/1", got.size(), done_cnt);
        end
        for (int i = 0; i < got.size() && i < 36; i++) begin
            total++;
            if (got[i] !== exp_res(i)) begin
                bad++;
                $display("FAIL rst_f1_res[%0d] got=%h exp=%h", i, got[i], exp_res(i));
            end
        end
        clear_log();
        start_i = 1'b1;
        @(posedge clock); #1 start_i = 1'b0;
        total++;
        if (pix_ready_o !== 1'b1 || busy_o !== 1'b1) begin
            bad++;
            $display("FAIL rst_f2_start rdy=%b busy=%b exp 1/1", pix_ready_o, busy_o);
        end
        feed(64, 1'b0, -1, fed);
        wait_done(ok);
        total++;
        if (fed !== 64 || !ok || got.size() !== 36) begin
            bad++;
            $display("FAIL rst_f2_count fed=%0d done=%0b got=%0d exp 64/1/36", fed, ok, got.size());
        end
        for (int i = 0; i < got.size() && i < 36; i++) begin
            total++;
            if (got[i] !== exp_res(i)) begin
                bad++;
                $display("FAIL rst_f2_res[%0d] got=%h exp=%h", i, got[i], exp_res(i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_backpressure();
        test_random();
        test_midreset();
        test_restart();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
